// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/response handshake bundle for the alu_muldiv
// execute unit.
//   in_*   request channel: valid/ready, op select, operands, pass-through tag
//   out_*  response channel: valid/ready, result, echoed tag
// Modports:
//   master  the issuing side (EX-stage control / testbench)
//   slave   the execute unit
interface alu_muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage execute unit covering the base integer ALU ops and the
// M-extension (multiply, divide, remainder).
//   clk    clock, rising edge
//   rst    synchronous active-high reset, highest priority
//   flush  abort any in-flight op; nothing is produced for it
//   busy   high whenever the unit is not idle
//   bus    alu_muldiv_if.slave handshake (request in, result out)
// Base ops and divide special cases complete in 1 cycle, the multiply group
// in 2, normal divide/remainder in XLEN+1 via a restoring divider.
module alu_muldiv #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  output logic        busy,
  alu_muldiv_if.slave bus
);
  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLT    = 5'd5;
  localparam logic [4:0] OP_SLTU   = 5'd6;
  localparam logic [4:0] OP_SLL    = 5'd7;
  localparam logic [4:0] OP_SRL    = 5'd8;
  localparam logic [4:0] OP_SRA    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic              out_valid_q;
  logic [XLEN-1:0]   out_result_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] mul_a, mul_b;
  logic              mul_hi;
  logic [XLEN-1:0]   div_q, div_r, div_d;
  logic              neg_q, neg_r, want_rem;

  // Handshake outputs depend on state only (plus reset gating of in_ready).
  assign bus.in_ready   = (state == S_IDLE) && !rst;
  assign busy           = (state != S_IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;

  // ---------------- request decode ----------------
  logic [XLEN-1:0] a, b;
  logic [SH_W-1:0] shamt;
  logic            is_mul, is_div, div_signed, div_rem, b_zero, div_ovf;
  logic            a_neg, b_neg, mul_a_sx, mul_b_sx;
  logic [XLEN-1:0] a_mag, b_mag, base_res, imm_res;

  assign a          = bus.in_a;
  assign b          = bus.in_b;
  assign shamt      = b[SH_W-1:0];
  assign is_mul     = bus.in_op inside {[OP_MUL:OP_MULHU]};
  assign is_div     = bus.in_op inside {[OP_DIV:OP_REMU]};
  assign div_signed = (bus.in_op == OP_DIV) || (bus.in_op == OP_REM);
  assign div_rem    = (bus.in_op == OP_REM) || (bus.in_op == OP_REMU);
  assign b_zero     = (b == '0);
  assign div_ovf    = div_signed && (a == MOST_NEG) && (b == '1);
  assign a_neg      = div_signed && a[XLEN-1];
  assign b_neg      = div_signed && b[XLEN-1];
  assign a_mag      = a_neg ? -a : a;
  assign b_mag      = b_neg ? -b : b;
  // Only MULH treats b as signed; MULH and MULHSU treat a as signed.
  assign mul_a_sx   = ((bus.in_op == OP_MULH) || (bus.in_op == OP_MULHSU)) && a[XLEN-1];
  assign mul_b_sx   = (bus.in_op == OP_MULH) && b[XLEN-1];

  always_comb begin
    base_res = {(XLEN/32){32'hDEADBEEF}};
    case (bus.in_op)
      OP_ADD:  base_res = a + b;
      OP_SUB:  base_res = a - b;
      OP_AND:  base_res = a & b;
      OP_OR:   base_res = a | b;
      OP_XOR:  base_res = a ^ b;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, a < b};
      OP_SLL:  base_res = a << shamt;
      OP_SRL:  base_res = a >> shamt;
      OP_SRA:  base_res = XLEN'($signed(a) >>> shamt);
      default: ;
    endcase
  end

  // Single-cycle result: base op, undefined op, or a divide special case.
  always_comb begin
    imm_res = base_res;
    if (is_div) begin
      if (b_zero) imm_res = div_rem ? a : '1;
      else        imm_res = div_rem ? '0 : a;  // signed overflow
    end
  end

  // ---------------- datapath steps ----------------
  // Sign-extending to 2*XLEN makes the truncated unsigned product correct
  // for every signedness combination.
  logic [2*XLEN-1:0] prod;
  assign prod = mul_a * mul_b;

  // One restoring-division step: shift in the next dividend bit, try to
  // subtract the divisor, keep the difference if it did not go negative.
  logic [XLEN:0]   r_sh, r_diff;
  logic [XLEN-1:0] q_nxt, r_nxt, q_fix, r_fix;
  assign r_sh   = {div_r, div_q[XLEN-1]};
  assign r_diff = r_sh - {1'b0, div_d};
  assign q_nxt  = {div_q[XLEN-2:0], ~r_diff[XLEN]};
  assign r_nxt  = r_diff[XLEN] ? r_sh[XLEN-1:0] : r_diff[XLEN-1:0];
  assign q_fix  = neg_q ? -q_nxt : q_nxt;
  assign r_fix  = neg_r ? -r_nxt : r_nxt;

  // ---------------- control ----------------
  // NOTE: every register here uses non-blocking assignment so all of them
  // sample pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      cnt          <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      mul_hi       <= 1'b0;
      div_q        <= '0;
      div_r        <= '0;
      div_d        <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      want_rem     <= 1'b0;
    end else if (flush) begin
      state       <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          out_tag_q <= bus.in_tag;
          if (is_mul) begin
            state  <= S_MUL;
            mul_a  <= {{XLEN{mul_a_sx}}, a};
            mul_b  <= {{XLEN{mul_b_sx}}, b};
            mul_hi <= (bus.in_op != OP_MUL);
          end else if (is_div && !b_zero && !div_ovf) begin
            state    <= S_DIV;
            cnt      <= CNT_W'(XLEN);
            div_q    <= a_mag;
            div_r    <= '0;
            div_d    <= b_mag;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            want_rem <= div_rem;
          end else begin
            state        <= S_DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= imm_res;
          end
        end
        S_MUL: begin
          state        <= S_DONE;
          out_valid_q  <= 1'b1;
          out_result_q <= mul_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end
        S_DIV: begin
          cnt   <= cnt - 1'b1;
          div_q <= q_nxt;
          div_r <= r_nxt;
          // Last quotient bit: apply the sign fix-up on the way into DONE.
          if (cnt == CNT_W'(1)) begin
            state        <= S_DONE;
            out_valid_q  <= 1'b1;
            out_result_q <= want_rem ? r_fix : q_fix;
          end
        end
        S_DONE: if (bus.out_ready) begin
          state       <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed self-checking bench for alu_muldiv. A 32-bit unit
// covers base ops, multiply, divide, special cases, back-pressure, flush and
// mid-operation reset; a 64-bit unit covers the wide divide and op filler.
module tb_alu_muldiv;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, busy32, busy64;
  int   checks = 0;
  int   errors = 0;

  alu_muldiv_if #(.XLEN(32), .TAG_W(5)) b32 ();
  alu_muldiv_if #(.XLEN(64), .TAG_W(5)) b64 ();

  alu_muldiv #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .busy(busy32), .bus(b32)
  );
  alu_muldiv #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .busy(busy64), .bus(b64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 32-bit unit, measure latency, check result/tag,
  // optionally hold out_ready low for 'hold' cycles, then release.
  task automatic run_op(input string name, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp,
                        input int exp_lat, input int hold);
    int   lat;
    logic rdy_seen, stable;
    check({name, " in_ready"}, b32.in_ready, 1'b1);
    b32.in_op    = op;
    b32.in_a     = a;
    b32.in_b     = b;
    b32.in_tag   = tag;
    b32.in_valid = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    lat      = 1;
    rdy_seen = 1'b0;
    while (!b32.out_valid && lat < 100) begin
      rdy_seen |= b32.in_ready;
      tick();
      lat++;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " result"}, b32.out_result, exp);
    check({name, " tag"}, b32.out_tag, tag);
    if (exp_lat > 1) check({name, " in_ready low"}, rdy_seen, 1'b0);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (b32.out_valid !== 1'b1 || b32.out_result !== exp ||
          b32.out_tag !== tag || b32.in_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) check({name, " held stable"}, stable, 1'b1);
    b32.out_ready = 1'b1;
    tick();
    b32.out_ready = 1'b0;
    check({name, " released"}, b32.out_valid, 1'b0);
  endtask

  initial begin
    int   lat;
    logic seen;

    rst = 1'b1;
    flush = 1'b0;
    b32.in_valid = 1'b0; b32.in_op = '0; b32.in_a = '0; b32.in_b = '0;
    b32.in_tag = '0; b32.out_ready = 1'b0;
    b64.in_valid = 1'b0; b64.in_op = '0; b64.in_a = '0; b64.in_b = '0;
    b64.in_tag = '0; b64.out_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst in_ready", b32.in_ready, 1'b0);
    check("rst busy", busy32, 1'b0);
    check("rst out_valid", b32.out_valid, 1'b0);
    check("rst out_result", b32.out_result, 32'h0);
    check("rst out_tag", b32.out_tag, 5'h0);
    rst = 1'b0;
    tick();

    // Base ops
    run_op("add",   5'd0,  32'd7,          32'd5,          5'd1, 32'd12,         1, 0);
    run_op("sub",   5'd1,  32'd5,          32'd7,          5'd2, 32'hFFFFFFFE,   1, 0);
    run_op("sra",   5'd9,  32'h80000000,   32'd4,          5'd3, 32'hF8000000,   1, 0);
    run_op("slt",   5'd5,  32'hFFFFFFFF,   32'd1,          5'd4, 32'd1,          1, 0);
    run_op("sltu",  5'd6,  32'hFFFFFFFF,   32'd1,          5'd5, 32'd0,          1, 0);
    run_op("sll",   5'd7,  32'd1,          32'h0000003F,   5'd6, 32'h80000000,   1, 0);
    run_op("undef", 5'd20, 32'd1,          32'd2,          5'd7, 32'hDEADBEEF,   1, 0);

    // Multiply group
    run_op("mulh",   5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'h00000000, 2, 0);
    run_op("mulhu",  5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'hFFFFFFFE, 2, 0);
    run_op("mulhsu", 5'd12, 32'hFFFFFFFF, 32'd2,        5'd10, 32'hFFFFFFFF, 2, 0);
    run_op("mul",    5'd10, 32'h00010000, 32'h00010000, 5'd11, 32'h00000000, 2, 0);

    // Divide / remainder
    run_op("div",  5'd14, 32'hFFFFFFF9, 32'd2,        5'd12, 32'hFFFFFFFD, 33, 0);
    run_op("rem",  5'd16, 32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFF, 33, 0);
    run_op("rem2", 5'd16, 32'd7,        32'hFFFFFFFE, 5'd14, 32'd1,        33, 0);
    run_op("divu", 5'd15, 32'd100,      32'd7,        5'd15, 32'd14,       33, 10);
    run_op("remu", 5'd17, 32'd100,      32'd7,        5'd16, 32'd2,        33, 0);

    // Special cases
    run_op("div0",   5'd14, 32'd5,        32'd0,        5'd17, 32'hFFFFFFFF, 1, 0);
    run_op("rem0",   5'd16, 32'd5,        32'd0,        5'd18, 32'd5,        1, 0);
    run_op("divovf", 5'd14, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 1, 0);
    run_op("removf", 5'd16, 32'h80000000, 32'hFFFFFFFF, 5'd20, 32'd0,        1, 0);

    // Flush at cycle 10 of a divide
    b32.in_op = 5'd15; b32.in_a = 32'd100; b32.in_b = 32'd7; b32.in_tag = 5'd21;
    b32.in_valid = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    repeat (9) tick();
    check("flush div busy before", busy32, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush div out_valid", b32.out_valid, 1'b0);
    check("flush div in_ready", b32.in_ready, 1'b1);
    check("flush div busy", busy32, 1'b0);

    // A request presented together with flush is dropped
    b32.in_op = 5'd0; b32.in_a = 32'd3; b32.in_b = 32'd4; b32.in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    b32.in_valid = 1'b0;
    check("flush req not accepted", busy32, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen |= b32.out_valid;
    end
    check("flush no late result", seen, 1'b0);
    run_op("add after flush", 5'd0, 32'h7FFFFFFF, 32'd1, 5'd22, 32'h80000000, 1, 0);

    // Flush in DONE beats out_ready
    b32.in_op = 5'd0; b32.in_a = 32'd1; b32.in_b = 32'd1; b32.in_tag = 5'd9;
    b32.in_valid = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    check("done before flush", b32.out_valid, 1'b1);
    flush = 1'b1;
    b32.out_ready = 1'b1;
    tick();
    flush = 1'b0;
    b32.out_ready = 1'b0;
    check("flush done out_valid", b32.out_valid, 1'b0);
    check("flush done busy", busy32, 1'b0);

    // Reset at cycle 5 of a divide
    b32.in_op = 5'd14; b32.in_a = 32'd100; b32.in_b = 32'd7; b32.in_tag = 5'd23;
    b32.in_valid = 1'b1;
    tick();
    b32.in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("mid rst out_valid", b32.out_valid, 1'b0);
    check("mid rst out_result", b32.out_result, 32'h0);
    check("mid rst out_tag", b32.out_tag, 5'h0);
    check("mid rst busy", busy32, 1'b0);
    check("mid rst in_ready", b32.in_ready, 1'b0);
    rst = 1'b0;
    tick();
    check("post rst in_ready", b32.in_ready, 1'b1);

    // XLEN=64: wide unsigned divide
    b64.in_op = 5'd15; b64.in_a = 64'h8000000000000000; b64.in_b = 64'd3;
    b64.in_tag = 5'd3; b64.in_valid = 1'b1;
    tick();
    b64.in_valid = 1'b0;
    lat = 1;
    while (!b64.out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("x64 divu latency", lat, 65);
    check("x64 divu result", b64.out_result, 64'h2AAAAAAAAAAAAAAA);
    check("x64 divu tag", b64.out_tag, 5'd3);
    b64.out_ready = 1'b1;
    tick();
    b64.out_ready = 1'b0;

    // XLEN=64: undefined op fills the whole width
    b64.in_op = 5'd31; b64.in_tag = 5'd4; b64.in_valid = 1'b1;
    tick();
    b64.in_valid = 1'b0;
    check("x64 undef valid", b64.out_valid, 1'b1);
    check("x64 undef result", b64.out_result, 64'hDEADBEEFDEADBEEF);
    b64.out_ready = 1'b1;
    tick();
    b64.out_ready = 1'b0;
    check("x64 busy after", busy64, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised, handshaked execute unit: the base RV integer ALU operations plus the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). Sits in the EX stage behind the operand-forwarding muxes and in front of the EX/MEM register. Base ops and multiply complete in fixed short latency; divide/remainder uses an iterative restoring divider. A flush input aborts an in-flight operation on branch mispredict or trap.

## Interface
- XLEN, 32: operand/result width; legal values 32 or 64.
- TAG_W, 5: width of the pass-through tag (destination register index).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  abort any in-flight op; no result is produced for it.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request this cycle.
- in_op  in  5  operation select (encoding below).
- in_a, in_b  in  XLEN  operands.
- in_tag  in  TAG_W  carried unchanged to out_tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the op that produced out_result.
- busy  out  1  high whenever state is not IDLE.

## Operation
- Op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; 18-31 undefined -> result is 32'hDEADBEEF replicated to XLEN.
- Shift amount = in_b[$clog2(XLEN)-1:0]; SLT/SLTU result is 1 or 0 zero-extended.
- MUL: low XLEN of product; MULH/MULHSU/MULHU: high XLEN of 2*XLEN product, signedness signed*signed, signed*unsigned, unsigned*unsigned.
- DIV/REM signed, truncate toward zero; remainder takes dividend's sign.
- Divide by zero: DIV/DIVU -> all ones; REM/REMU -> in_a.
- Signed overflow (in_a = most-negative, in_b = -1): DIV -> in_a, REM -> 0.
- Divider: operands converted to magnitudes at accept, one quotient bit per cycle for XLEN cycles, sign fix-up applied when entering DONE.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: in_ready = 1. On accept (in_valid & in_ready): base/undefined ops and div special cases (zero divisor, overflow) -> DONE; MUL-group -> MUL; other div/rem -> DIV with counter = XLEN.
  - MUL: one cycle (registered partial product), -> DONE.
  - DIV: counter decrements each cycle; at counter reaching 0 -> DONE.
  - DONE: out_valid = 1, out_result/out_tag stable; on out_ready -> IDLE.
- in_ready is 0 in every state other than IDLE; no request overlaps an in-flight op.
- flush (when rst low): any state -> IDLE next cycle, out_valid drops next cycle, a request presented with flush is not accepted. flush in DONE discards the pending result even if out_ready is high that cycle.
- rst has priority over flush and all handshakes.

## Timing
- Reset values: state IDLE, out_valid 0, out_result 0, out_tag 0, busy 0, divider counter 0; in_ready is 0 while rst is high.
- Accept at edge N: out_valid asserted after edge N+1 (base, undefined, div special cases), N+2 (MUL-group), N+1+XLEN (normal DIV/REM; 33 cycles at XLEN=32).
- Back-pressure: DONE holds indefinitely with out_valid high and outputs unchanged until out_ready.
- Minimum issue interval = latency + 1 (one IDLE cycle between results).
- out_valid and out_result are registered; in_ready and busy are decoded from state only (no combinational path from in_valid/out_ready).

## Test plan
- Base ops at XLEN=32: ADD 7+5 -> 12, SUB 5-7 -> 0xFFFFFFFE, SRA 0x80000000>>>4 -> 0xF8000000, SLT -1<1 -> 1, op 20 -> 0xDEADBEEF; each out_valid 1 cycle after accept, tag echoed.
- Multiply: MULH 0xFFFFFFFF*0xFFFFFFFF -> 0; MULHU same -> 0xFFFFFFFE; MULHSU -1*2 -> 0xFFFFFFFF; MUL 0x10000*0x10000 -> 0; latency 2.
- Divide: DIV -7/2 -> -3, REM -7/2 -> -1, DIVU 100/7 -> 14, REMU -> 2; out_valid exactly 33 cycles after accept, in_ready low throughout.
- Special cases: DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM -> 0; latency 1.
- Back-pressure and flush: hold out_ready low 10 cycles in DONE -> result stable; assert flush at cycle 10 of a DIV -> no out_valid, in_ready high next cycle, next ADD completes correctly.
- Reset mid-DIV and XLEN=64 regression: rst at cycle 5 of a DIV -> all outputs at reset values next cycle; XLEN=64 DIVU 2^63/3 -> 0x2AAAAAAAAAAAAAAA after 65 cycles.
